// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern driver family: mode encodings and
// the active-low drive levels used at the board pins.
package led_pkg;

  typedef enum logic [1:0] {
    LED_MODE_OFF     = 2'd0,
    LED_MODE_BLINK   = 2'd1,
    LED_MODE_CHASE   = 2'd2,
    LED_MODE_BREATHE = 2'd3
  } led_mode_e;

  localparam logic LED_ACTIVE = 1'b0;
  localparam logic LED_IDLE   = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Shared tick generator: counts 0..CNT_MAX and wraps. `wrap` is the
// combinational wrap event; `tick` is its registered one-cycle copy.
// `clr` restarts the count and swallows a wrap occurring in the same cycle.
module led_tick_gen #(
  parameter logic [31:0] CNT_MAX = 32'd24_999_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic wrap,
  output logic tick
);

  localparam int W = (CNT_MAX < 32'd1) ? 1 : $clog2({1'b0, CNT_MAX} + 33'd1);
  localparam logic [W-1:0] CNT_LAST = CNT_MAX[W-1:0];

  logic [W-1:0] cnt;

  assign wrap = (cnt == CNT_LAST) && !clr;

  // Free-running counter with synchronous clear; tick mirrors wrap one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      if (clr || (cnt == CNT_LAST)) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel active-low LED pattern driver: OFF, BLINK, CHASE, BREATHE.
// Optional feature macro: LED_BREATHE_EN compiles in the PWM counter and
// duty logic; without it mode 3 decodes as OFF.
// The LED register is loaded from next-state values so a mode load or a tick
// wrap is visible on `led` in the very next cycle.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter logic [31:0] CNT_MAX  = 32'd24_999_999,
  parameter int          LED_NUM  = 4,
  parameter int          PWM_BITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               system_en,
  input  logic [1:0]         mode,
  input  logic               mode_vld,
  output logic [LED_NUM-1:0] led,
  output logic               tick,
  output led_mode_e          cur_mode
);

  localparam int POS_W = $clog2(LED_NUM);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_NUM - 1);

  logic clr;
  logic wrap;

  // Any mode load or a disabled system restarts the pattern from its origin.
  assign clr = mode_vld || !system_en;

  led_tick_gen #(.CNT_MAX(CNT_MAX)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .wrap  (wrap),
    .tick  (tick)
  );

  led_mode_e          mode_q, mode_d, mode_dec;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               blink_q, blink_d;
  logic [LED_NUM-1:0] led_d;

`ifdef LED_BREATHE_EN
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_q, dir_d;   // 0 = up, 1 = down
  assign mode_dec = led_mode_e'(mode);
`else
  localparam int UNUSED_PWM_BITS = PWM_BITS;
  assign mode_dec = (led_mode_e'(mode) == LED_MODE_BREATHE) ? LED_MODE_OFF
                                                            : led_mode_e'(mode);
`endif

  assign cur_mode = mode_q;

  // State and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= LED_MODE_OFF;
      pos_q   <= '0;
      blink_q <= 1'b0;
      led     <= {LED_NUM{LED_IDLE}};
`ifdef LED_BREATHE_EN
      pwm_q   <= '0;
      duty_q  <= '0;
      dir_q   <= 1'b0;
`endif
    end else begin
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      blink_q <= blink_d;
      led     <= led_d;
`ifdef LED_BREATHE_EN
      pwm_q   <= pwm_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
`endif
    end
  end

  // Next-state for mode, pattern state and the LED image derived from it.
  always_comb begin
    mode_d  = mode_q;
    pos_d   = pos_q;
    blink_d = blink_q;
    led_d   = {LED_NUM{LED_IDLE}};
`ifdef LED_BREATHE_EN
    pwm_d   = pwm_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
`endif

    if (mode_vld) mode_d = mode_dec;

    if (clr) begin
      pos_d   = '0;
      blink_d = 1'b0;
`ifdef LED_BREATHE_EN
      pwm_d   = '0;
      duty_d  = '0;
      dir_d   = 1'b0;
`endif
    end else begin
`ifdef LED_BREATHE_EN
      pwm_d = pwm_q + 1'b1;
`endif
      if (wrap) begin
        blink_d = !blink_q;
        pos_d   = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
`ifdef LED_BREATHE_EN
        // Endpoints hold for one tick: the reversal itself does not step duty.
        if (!dir_q) begin
          if (duty_q == {PWM_BITS{1'b1}}) dir_d  = 1'b1;
          else                            duty_d = duty_q + 1'b1;
        end else begin
          if (duty_q == '0) dir_d  = 1'b0;
          else              duty_d = duty_q - 1'b1;
        end
`endif
      end
    end

    if (system_en) begin
      case (mode_d)
        LED_MODE_BLINK: if (blink_d) led_d = {LED_NUM{LED_ACTIVE}};
        LED_MODE_CHASE: led_d[pos_d] = LED_ACTIVE;
`ifdef LED_BREATHE_EN
        LED_MODE_BREATHE: if (pwm_d < duty_d) led_d = {LED_NUM{LED_ACTIVE}};
`endif
        default: led_d = {LED_NUM{LED_IDLE}};
      endcase
    end
  end

endmodule
